// File: rtl/scytale_decryption_if.sv
// scytale_decryption_if: character stream in, plaintext stream and status out
interface scytale_decryption_if #(
    parameter int D_WIDTH   = 8,
    parameter int KEY_WIDTH = 8
) ();
    logic [D_WIDTH-1:0]   data_i;
    logic                 valid_i;
    logic [KEY_WIDTH-1:0] key_N;
    logic [KEY_WIDTH-1:0] key_M;
    logic [D_WIDTH-1:0]   data_o;
    logic                 valid_o;
    logic                 busy;
    logic                 err_o;

    modport master (
        output data_i, valid_i, key_N, key_M,
        input  data_o, valid_o, busy, err_o
    );

    modport slave (
        input  data_i, valid_i, key_N, key_M,
        output data_o, valid_o, busy, err_o
    );
endinterface

// File: rtl/scytale_decryption.sv
// scytale_decryption: buffers ciphertext until a start token, then streams the Scytale plaintext
module scytale_decryption #(
    parameter int                 D_WIDTH         = 8,
    parameter int                 KEY_WIDTH       = 8,
    parameter int                 MAX_NOF_CHARS   = 50,
    parameter logic [D_WIDTH-1:0] START_DEC_TOKEN = 8'hFA
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    scytale_decryption_if.slave  bus
);
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int PW = 2 * KEY_WIDTH;

    typedef enum logic [1:0] {COLLECT, DECRYPT, FINISH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]        addr_q, addr_d;
    logic [KEY_WIDTH-1:0] key_n_q, key_n_d;
    logic [KEY_WIDTH-1:0] key_m_q, key_m_d;
    logic [KEY_WIDTH-1:0] i_q, i_d;
    logic [KEY_WIDTH-1:0] j_q, j_d;
    logic [D_WIDTH-1:0]   data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 wr_en;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        addr_sum;
    logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];

    assign prod     = PW'(bus.key_N) * PW'(bus.key_M);
    assign addr_sum = PW'(addr_q) + PW'(key_n_q);

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.busy    = busy_q;
    assign bus.err_o   = err_q;

    // next-state: collect/validate on token, walk columns of the buffer while decrypting
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        addr_d   = addr_q;
        key_n_d  = key_n_q;
        key_m_d  = key_m_q;
        i_d      = i_q;
        j_d      = j_q;
        data_d   = '0;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.valid_i && bus.data_i != START_DEC_TOKEN) begin
                    if (wr_cnt_q != CW'(MAX_NOF_CHARS)) begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end else if (bus.valid_i) begin
                    key_n_d = bus.key_N;
                    key_m_d = bus.key_M;
                    if (wr_cnt_q == '0) begin
                        state_d = COLLECT;
                    end else if (bus.key_N == '0 || bus.key_M == '0 || prod != PW'(wr_cnt_q)) begin
                        err_d    = 1'b1;
                        wr_cnt_d = '0;
                    end else begin
                        i_d     = '0;
                        j_d     = '0;
                        addr_d  = '0;
                        state_d = DECRYPT;
                    end
                end
            end
            DECRYPT: begin
                data_d  = mem_q[addr_q];
                valid_d = 1'b1;
                if (j_q == key_m_q - KEY_WIDTH'(1)) begin
                    j_d    = '0;
                    i_d    = i_q + KEY_WIDTH'(1);
                    addr_d = CW'(i_q + KEY_WIDTH'(1));
                    if (i_q == key_n_q - KEY_WIDTH'(1))
                        state_d = FINISH;
                end else begin
                    j_d    = j_q + KEY_WIDTH'(1);
                    addr_d = CW'(addr_sum);
                end
            end
            default: begin
                wr_cnt_d = '0;
                state_d  = COLLECT;
            end
        endcase
        busy_d = state_d != COLLECT;
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            wr_cnt_q <= '0;
            addr_q   <= '0;
            key_n_q  <= '0;
            key_m_q  <= '0;
            i_q      <= '0;
            j_q      <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            addr_q   <= addr_d;
            key_n_q  <= key_n_d;
            key_m_q  <= key_m_d;
            i_q      <= i_d;
            j_q      <= j_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // character buffer; contents are don't-care after reset so it has none
    always_ff @(posedge clk_sys) begin
        if (wr_en)
            mem_q[wr_cnt_q] <= bus.data_i;
    end
endmodule

// File: tb/tb_scytale_decryption.sv
// tb_scytale_decryption: random and directed messages checked by a queue scoreboard
module tb_scytale_decryption;
    typedef struct {
        bit         err;
        logic [7:0] d;
    } exp_t;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    exp_t exp_q[$];
    logic [7:0] mbuf[$];
    logic [7:0] msg_q[$];
    exp_t e_mon;

    scytale_decryption_if bus ();

    scytale_decryption dut (.clk_sys(clk_sys), .rst_n(rst_n), .bus(bus));

    always #5 clk_sys = ~clk_sys;

    // monitor: pop an expectation for every valid_o or err_o cycle
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (bus.valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got data_o=%h, nothing expected", bus.data_o);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (e_mon.err || bus.data_o !== e_mon.d) begin
                        errors++;
                        $display("FAIL out_data: got data_o=%h, expected err=%0d data=%h", bus.data_o, e_mon.err, e_mon.d);
                    end
                end
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during_out: got busy=%b, expected 1", bus.busy);
                end
            end else begin
                checks++;
                if (bus.data_o !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_data: got data_o=%h, expected 00", bus.data_o);
                end
            end
            if (bus.err_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_err: got err_o=1, nothing expected");
                end else begin
                    e_mon = exp_q.pop_front();
                    if (!e_mon.err) begin
                        errors++;
                        $display("FAIL err_order: got err_o=1, expected data %h", e_mon.d);
                    end
                end
            end
        end
    end

    // reference: Scytale read-out is column by column over a row-major N-wide grid
    function automatic bit model_token(input int n, input int m);
        exp_t e;
        int len = mbuf.size();
        if (len == 0) return 1'b0;
        if (n == 0 || m == 0 || n * m != len) begin
            e.err = 1'b1;
            e.d   = 8'h00;
            exp_q.push_back(e);
            mbuf.delete();
            return 1'b0;
        end
        for (int c = 0; c < n; c++)
            for (int r = 0; r < m; r++) begin
                e.err = 1'b0;
                e.d   = mbuf[r * n + c];
                exp_q.push_back(e);
            end
        mbuf.delete();
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (bus.busy === 1'b1 && t < 500) begin
            bus.valid_i = 1'b1;
            bus.data_i  = 8'($urandom_range(0, 249));
            bus.key_N   = 8'($urandom);
            bus.key_M   = 8'($urandom);
            @(posedge clk_sys);
            #1;
            t++;
        end
        bus.valid_i = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: got busy=%b after %0d cycles, expected 0", bus.busy, t);
        end
    endtask

    task automatic send_msg(input int n, input int m, input bit gaps);
        bit ok;
        wait_idle();
        foreach (msg_q[k]) begin
            bus.valid_i = 1'b1;
            bus.data_i  = msg_q[k];
            if (mbuf.size() < 50) mbuf.push_back(msg_q[k]);
            @(posedge clk_sys);
            #1;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.valid_i = 1'b0;
                @(posedge clk_sys);
                #1;
            end
        end
        bus.valid_i = 1'b1;
        bus.data_i  = 8'hFA;
        bus.key_N   = 8'(n);
        bus.key_M   = 8'(m);
        ok = model_token(n, m);
        @(posedge clk_sys);
        #1;
        bus.valid_i = 1'b0;
        bus.key_N   = 8'($urandom);
        bus.key_M   = 8'($urandom);
        checks++;
        if (bus.busy !== ok || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL token_busy: got busy=%b valid_o=%b, expected busy=%b valid_o=0", bus.busy, bus.valid_o, ok);
        end
    endtask

    task automatic load(input string s);
        msg_q.delete();
        for (int k = 0; k < s.len(); k++) msg_q.push_back(s[k]);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.data_o !== 8'h00 || bus.valid_o !== 1'b0 || bus.busy !== 1'b0 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got data_o=%h valid_o=%b busy=%b err_o=%b, expected all 0", name, bus.data_o, bus.valid_o, bus.busy, bus.err_o);
        end
    endtask

    initial begin
        int n, m, len;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.key_N   = 8'h00;
        bus.key_M   = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        load("ABCDEF"); send_msg(2, 3, 1'b0);
        load("ABCDEF"); send_msg(3, 2, 1'b0);
        load("XY");     send_msg(1, 2, 1'b0);
        load("ABC");    send_msg(2, 2, 1'b0);
        load("WXYZ");   send_msg(2, 2, 1'b0);
        msg_q.delete(); send_msg(3, 3, 1'b0);
        msg_q.delete();
        for (int k = 0; k < 52; k++) msg_q.push_back(8'($urandom_range(0, 249)));
        send_msg(5, 10, 1'b0);
        load("ABCDEF"); send_msg(2, 3, 1'b0);
        @(posedge clk_sys);
        #1;
        @(posedge clk_sys);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        exp_q.delete();
        mbuf.delete();
        repeat (2) @(posedge clk_sys);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;
        load("ABCDEF"); send_msg(2, 3, 1'b0);
        load("ABCD");   send_msg(0, 4, 1'b0);
        for (int r = 0; r < 25; r++) begin
            n   = $urandom_range(1, 7);
            m   = $urandom_range(1, 7);
            len = n * m;
            if ($urandom_range(0, 4) == 0) len = len + 1;
            msg_q.delete();
            for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom_range(0, 249)));
            send_msg(n, m, 1'b1);
        end
        wait_idle();
        repeat (4) @(posedge clk_sys);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
